// File: rtl/mult_pkg.sv
// ============================================================================
// Module : mult_pkg
// Brief  : Shared constants, mode encoding and Wallace-tree sizing helpers.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mult_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_TRUNC = 4;
  localparam int LATENCY   = 3;

  typedef enum logic [1:0] {
    EXACT_U  = 2'd0,
    EXACT_S  = 2'd1,
    APPROX_U = 2'd2
  } mode_e;

  // Row count left after `lvls` levels of 3:2 compression, starting from n0 rows.
  function automatic int rows_after(input int n0, input int lvls);
    int n;
    n = n0;
    for (int l = 0; l < lvls; l++) begin
      n = (n / 3) * 2 + (n % 3);
    end
    return n;
  endfunction

  function automatic int wallace_levels(input int n0);
    int n;
    int l;
    n = n0;
    l = 0;
    while (n > 2) begin
      n = (n / 3) * 2 + (n % 3);
      l++;
    end
    return l;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipelined_wallace_mult_csa_row.sv
// ============================================================================
// Module : csa_row
// Brief  : Row of 3:2 full-adder compressors; carry vector is pre-shifted.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module csa_row #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_y,
  input  logic [WIDTH-1:0] i_z,
  output logic [WIDTH-1:0] o_sum,
  output logic [WIDTH-1:0] o_carry
);

  logic [WIDTH-2:0] w_maj;

  assign o_sum   = i_x ^ i_y ^ i_z;
  // The carry out of the top column falls outside the modulo-2^WIDTH product.
  assign w_maj   = (i_x[WIDTH-2:0] & i_y[WIDTH-2:0]) |
                   (i_x[WIDTH-2:0] & i_z[WIDTH-2:0]) |
                   (i_y[WIDTH-2:0] & i_z[WIDTH-2:0]);
  assign o_carry = {w_maj, 1'b0};

endmodule

`default_nettype wire

// File: rtl/pipelined_wallace_mult.sv
// ============================================================================
// Module : pipelined_wallace_mult
// Brief  : 3-stage Wallace-tree multiplier, unsigned/Baugh-Wooley/truncated.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipelined_wallace_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int TRUNC = DEF_TRUNC
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  input  logic               approx_en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result
);

  localparam int PW   = 2 * WIDTH;
  localparam int ROWS = WIDTH + 1;
  localparam int NLEV = wallace_levels(ROWS);

  logic             w_adv;
  logic             r_v1, r_v2, r_v3;
  logic [WIDTH-1:0] r_a1, r_b1;
  mode_e            r_mode1;
  logic [PW-1:0]    r_s2, r_c2, r_res;
  logic [PW-1:0]    w_pp  [ROWS];
  logic [PW-1:0]    w_lvl [NLEV+1][ROWS];

  assign w_adv     = ~(r_v3 & ~out_ready);
  assign in_ready  = rst | w_adv;
  assign out_valid = r_v3;
  assign result    = r_res;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1    <= 1'b0;
      r_a1    <= '0;
      r_b1    <= '0;
      r_mode1 <= EXACT_U;
    end else if (w_adv) begin
      r_v1 <= in_valid;
      if (in_valid) begin
        r_a1    <= a;
        r_b1    <= b;
        r_mode1 <= signed_mode ? EXACT_S : (approx_en ? APPROX_U : EXACT_U);
      end
    end
  end

  // Row i holds a*b[i] at column offset i; row WIDTH carries the Baugh-Wooley
  // correction ones at columns WIDTH and 2*WIDTH-1.
  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      w_pp[r] = '0;
    end
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        logic v_bit;
        v_bit = r_a1[j] & r_b1[i];
        if ((r_mode1 == EXACT_S) && ((i == WIDTH-1) != (j == WIDTH-1))) begin
          v_bit = ~v_bit;
        end
        if ((r_mode1 == APPROX_U) && (i + j < TRUNC)) begin
          v_bit = 1'b0;
        end
        w_pp[i][i+j] = v_bit;
      end
    end
    if (r_mode1 == EXACT_S) begin
      w_pp[WIDTH][WIDTH]  = 1'b1;
      w_pp[WIDTH][PW-1]   = 1'b1;
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_lvl0
    assign w_lvl[0][r] = w_pp[r];
  end

  for (genvar l = 0; l < NLEV; l++) begin : g_lvl
    localparam int N  = rows_after(ROWS, l);
    localparam int G  = N / 3;
    localparam int NN = rows_after(ROWS, l + 1);

    for (genvar g = 0; g < G; g++) begin : g_csa
      csa_row #(.WIDTH(PW)) u_csa (
        .i_x     (w_lvl[l][3*g]),
        .i_y     (w_lvl[l][3*g+1]),
        .i_z     (w_lvl[l][3*g+2]),
        .o_sum   (w_lvl[l+1][2*g]),
        .o_carry (w_lvl[l+1][2*g+1])
      );
    end

    for (genvar r = 3*G; r < N; r++) begin : g_pass
      assign w_lvl[l+1][r-G] = w_lvl[l][r];
    end

    for (genvar r = NN; r < ROWS; r++) begin : g_zero
      assign w_lvl[l+1][r] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v2 <= 1'b0;
      r_s2 <= '0;
      r_c2 <= '0;
    end else if (w_adv) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_s2 <= w_lvl[NLEV][0];
        r_c2 <= w_lvl[NLEV][1];
      end
    end
  end

  // result only updates on a real beat so it holds across bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v3  <= 1'b0;
      r_res <= '0;
    end else if (w_adv) begin
      r_v3 <= r_v2;
      if (r_v2) begin
        r_res <= r_s2 + r_c2;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pipelined_wallace_mult.sv
// ============================================================================
// Module : tb_pipelined_wallace_mult
// Brief  : Self-checking bench with behavioural product model and scoreboard.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipelined_wallace_mult;

  localparam int W = 8;
  localparam int T = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           signed_mode = 1'b0;
  logic           approx_en = 1'b0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [2*W-1:0] result;

  int n_tests = 0;
  int n_fail  = 0;
  int n_out   = 0;
  logic [2*W-1:0] exp_q[$];
  logic           prev_stall = 1'b0;
  logic           prev_rst   = 1'b1;
  logic [2*W-1:0] prev_res   = '0;

  always #5 clk = ~clk;

  pipelined_wallace_mult #(.WIDTH(W), .TRUNC(T)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .signed_mode (signed_mode),
    .approx_en   (approx_en),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result)
  );

  function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic sm, input logic ae);
    logic [63:0] acc;
    acc = '0;
    if (sm) begin
      acc = 64'(longint'($signed(x)) * longint'($signed(y)));
    end else begin
      for (int i = 0; i < W; i++)
        for (int j = 0; j < W; j++)
          if (x[i] && y[j] && (!ae || (i + j >= T)))
            acc = acc + (64'd1 << (i + j));
    end
    return acc[2*W-1:0];
  endfunction

  task automatic check(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Scoreboard: every cycle the outputs are meaningful.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      check(in_ready == 1'b1, "in_ready_during_rst", 64'(in_ready), 64'd1);
    end else begin
      if (prev_rst) begin
        check(out_valid == 1'b0, "post_rst_out_valid", 64'(out_valid), 64'd0);
        check(result == '0, "post_rst_result", 64'(result), 64'd0);
      end
      check(in_ready == !(out_valid && !out_ready), "in_ready", 64'(in_ready),
            64'(!(out_valid && !out_ready)));
      if (prev_stall) begin
        check(out_valid && (result == prev_res), "stall_hold", 64'(result), 64'(prev_res));
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_result", 64'(result), 64'd0);
        end else begin
          check(result == exp_q[0], "result", 64'(result), 64'(exp_q[0]));
          if (out_ready) begin
            void'(exp_q.pop_front());
            n_out++;
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, signed_mode, approx_en));
      end
    end
    prev_rst   = rst;
    prev_stall = !rst && out_valid && !out_ready;
    prev_res   = result;
  end

  task automatic drive(input logic v, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic sm, input logic ae);
    in_valid = v; a = x; b = y; signed_mode = sm; approx_en = ae;
  endtask

  task automatic directed(input logic [W-1:0] x, input logic [W-1:0] y, input logic sm,
                          input logic ae, input logic [2*W-1:0] req, input string nm);
    int n;
    out_ready = 1'b1;
    @(posedge clk); #1;
    drive(1'b1, x, y, sm, ae);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    @(negedge clk);
    while (!out_valid && n < 10) begin
      n++;
      @(negedge clk);
    end
    check(n == 3, {nm, "_latency"}, 64'(n), 64'd3);
    check(out_valid && result == req, nm, 64'(result), 64'(req));
  endtask

  task automatic drain();
    int k;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    k = 0;
    while (exp_q.size() != 0 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check(exp_q.size() == 0, "drain", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic run_stream(input int nbeats, input bit rand_all, input int st0, input int stn);
    int  sent;
    int  cyc;
    bit  acc;
    sent = 0; cyc = 0; acc = 1'b1;
    while (sent < nbeats && cyc < nbeats * 20) begin
      @(posedge clk); #1;
      cyc++;
      if (!in_valid || acc) begin
        drive(rand_all ? ($urandom_range(0, 3) != 0) : 1'b1, W'($urandom), W'($urandom),
              1'($urandom), 1'($urandom));
      end
      out_ready = rand_all ? ($urandom_range(0, 3) != 0) : !(cyc >= st0 && cyc < st0 + stn);
      @(negedge clk);
      acc = in_valid && in_ready;
      if (acc) sent++;
    end
    check(sent == nbeats, "stream_sent", 64'(sent), 64'(nbeats));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int n;
    rst = 1'b1;
    drive(1'b1, 8'h12, 8'h34, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check(out_valid == 1'b0, "reset_out_valid", 64'(out_valid), 64'd0);
    check(result == '0, "reset_result", 64'(result), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);

    directed(8'd255, 8'd255, 1'b0, 1'b0, 16'hFE01, "u255x255");
    directed(8'd15,  8'd15,  1'b0, 1'b1, 16'h00B0, "approx15x15");
    directed(8'd15,  8'd15,  1'b0, 1'b0, 16'h00E1, "exact15x15");
    directed(8'hFF,  8'h01,  1'b1, 1'b1, 16'hFFFF, "signed_ignores_approx");

    // Back-to-back signed beats.
    @(posedge clk); #1;
    drive(1'b1, 8'h80, 8'h80, 1'b1, 1'b0);
    @(posedge clk); #1;
    drive(1'b1, 8'hFF, 8'h01, 1'b1, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 10) begin
      n++;
      @(negedge clk);
    end
    check(out_valid && result == 16'h4000, "s_m128xm128", 64'(result), 64'h4000);
    @(negedge clk);
    check(out_valid && result == 16'hFFFF, "s_m1x1", 64'(result), 64'hFFFF);
    drain();

    // Ten beats with a five-cycle output stall in the middle.
    n0 = n_out;
    run_stream(10, 1'b0, 4, 5);
    drain();
    check(n_out - n0 == 10, "stream10_count", 64'(n_out - n0), 64'd10);

    // Reset with three beats in flight (first one parked at the output).
    @(posedge clk); #1;
    drive(1'b1, 8'd3, 8'd5, 1'b0, 1'b0);
    out_ready = 1'b0;
    @(posedge clk); #1;
    drive(1'b1, 8'd7, 8'd9, 1'b1, 1'b0);
    @(posedge clk); #1;
    drive(1'b1, 8'd11, 8'd13, 1'b0, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 8'd99, 8'd99, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    check(exp_q.size() == 0, "flush_queue", 64'(exp_q.size()), 64'd0);
    directed(8'd200, 8'd3, 1'b0, 1'b0, 16'd600, "post_rst_beat");
    drain();

    // Random regression with random modes, valid and back-pressure.
    n0 = n_out;
    run_stream(20000, 1'b1, 0, 0);
    drain();
    check(n_out - n0 == 20000, "regress_count", 64'(n_out - n0), 64'd20000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
